// File: rtl/ysyx_22040237_pkg.sv
// ysyx_22040237 shared defines: opcodes, IFU state encoding,
// reset PC and instruction width. No ports.
package ysyx_22040237_pkg;

  localparam int INST_W = 32;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    IFU_REQ  = 2'd0,
    IFU_WAIT = 2'd1,
    IFU_OUT  = 2'd2
  } ifu_state_e;

  function automatic logic misaligned(
    input logic [31:0] a
  );
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: one outstanding imem request, redirect kill.
// Ports: clk, rst (async, active-low), redirect_*, imem_req_*, imem_rsp_*, inst_*.
module ysyx_22040237_ifu
  import ysyx_22040237_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_addr,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [31:0]       imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              imem_rsp_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [31:0]       inst_pc,
  output logic              inst_fault
);

  ifu_state_e        state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic              kill_q, kill_d;
  logic              live_q;
  logic [INST_W-1:0] data_q, data_d;
  logic [31:0]       ipc_q, ipc_d;
  logic              fault_q, fault_d;
  logic              req_on;
  logic              pc_bad;

  // live_q holds off the first request until one clock after reset release
  assign pc_bad = misaligned(pc_q);
  assign req_on = live_q && (state_q == IFU_REQ) && !pc_bad;

  assign imem_req_valid = req_on;
  assign imem_req_addr  = {pc_q[31:2], 2'b00};
  assign inst_valid     = (state_q == IFU_OUT);
  assign inst_data      = data_q;
  assign inst_pc        = ipc_q;
  assign inst_fault     = fault_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    data_d  = data_q;
    ipc_d   = ipc_q;
    fault_d = fault_q;
    unique case (state_q)
      IFU_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_addr;
          // request accepted under a redirect: absorb its response
          if (req_on && imem_req_ready) begin
            state_d = IFU_WAIT;
            kill_d  = 1'b1;
          end
        end else if (live_q && pc_bad) begin
          state_d = IFU_OUT;
          data_d  = '0;
          ipc_d   = pc_q;
          fault_d = 1'b1;
        end else if (req_on && imem_req_ready) begin
          state_d = IFU_WAIT;
        end
      end
      IFU_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_addr;
          if (imem_rsp_valid) begin
            state_d = IFU_REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (kill_q) begin
            state_d = IFU_REQ;
            kill_d  = 1'b0;
          end else begin
            state_d = IFU_OUT;
            data_d  = imem_rsp_err ? '0 : imem_rsp_data;
            ipc_d   = pc_q;
            fault_d = imem_rsp_err;
          end
        end
      end
      IFU_OUT: begin
        if (redirect_valid) begin
          pc_d    = redirect_addr;
          state_d = IFU_REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = IFU_REQ;
        end
      end
      default: begin
        state_d = IFU_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IFU_REQ;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      live_q  <= 1'b0;
      data_q  <= '0;
      ipc_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      live_q  <= 1'b1;
      data_q  <= data_d;
      ipc_q   <= ipc_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// Random bench for ysyx_22040237_ifu with memory model and scoreboard.
// Expected instruction stream is derived from redirect targets and pc+4.
module tb_ysyx_22040237_ifu;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_fault;

  ysyx_22040237_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    if (a == RPC) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic merr(input logic [31:0] a);
    return (a == 32'h8000_0008) || ((a[11:2] % 10'd23) == 10'd5);
  endfunction

  function automatic exp_t mk(input logic [31:0] a);
    exp_t e;
    e.pc    = a;
    e.fault = (a[1:0] != 2'b00) || merr(a);
    e.data  = e.fault ? 32'h0 : mdata(a);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] r;
    r = $urandom;
    case ($urandom % 8)
      0: return 32'h8000_0100;
      1: return 32'h8000_0202;
      2: return 32'hFFFF_FFFC;
      3: return 32'h8000_0008;
      4: return 32'hFFFF_FFF8;
      5: return {r[31:2], 2'b00};
      6: return r;
      default: return RPC;
    endcase
  endfunction

  // stimulus: reset, random handshake pressure and redirects
  task automatic do_reset(input int n);
    rst            = 1'b0;
    redirect_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      imem_req_ready = 1'b1;
      inst_ready     = 1'b0;
    end
  endtask

  initial begin
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 32'h0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    #1;
    do_reset(3);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (i == 1500) begin
        do_reset(2);
      end else begin
        imem_req_ready = ($urandom % 2) == 0;
        if (i >= 200 && i < 400)
          inst_ready = ($urandom % 6) == 0;
        else
          inst_ready = ($urandom % 3) != 0;
        redirect_valid = (i > 20) && (($urandom % 12) == 0);
        redirect_addr  = pick();
      end
    end
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    repeat (10) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // monitor, scoreboard and imem responder, all at negedge
  initial begin
    bit          pend = 0;
    logic [31:0] paddr = 0;
    int          lat = 0;
    int          cyc = 0;
    int          idle = 0;
    int          since = 0;
    bit          acc_v = 0;
    int          acc_c = 0;
    int          acc_l = 0;
    bit          rd_chk = 0;
    logic [31:0] rd_tgt = 0;
    bit          p_rst = 0, p_v = 0, p_rdy = 0, p_rd = 0;
    bit          p_rv = 0, p_rr = 0;
    logic [31:0] p_d = 0, p_pc = 0, p_ra = 0;
    bit          p_f = 0;
    exp_t        e;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        chk("rst_ctl",
            32'({imem_req_valid, inst_valid, inst_fault}), 32'h0);
        chk("rst_data", inst_data, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);
        sb.delete();
        sb.push_back(mk(RPC));
        pend   = 0;
        acc_v  = 0;
        rd_chk = 0;
        idle   = 0;
        since  = 0;
      end else begin
        since++;
        if (since == 2) begin
          chk("first_req", 32'(imem_req_valid), 32'h1);
          chk("first_addr", imem_req_addr, RPC);
        end
        if (p_rst && p_v && !p_rdy && !p_rd) begin
          chk("hold_valid", 32'(inst_valid), 32'h1);
          chk("hold_pc", inst_pc, p_pc);
          chk("hold_data", inst_data, p_d);
          chk("hold_fault", 32'(inst_fault), 32'(p_f));
        end
        if (inst_valid)
          chk("req_in_out", 32'(imem_req_valid), 32'h0);
        if (p_rst && p_rv && !p_rr && !p_rd) begin
          chk("req_hold", 32'(imem_req_valid), 32'h1);
          chk("req_hold_addr", imem_req_addr, p_ra);
        end
        if (imem_req_valid) begin
          chk("req_align", 32'(imem_req_addr[1:0]), 32'h0);
          chk("one_outstanding", 32'(pend), 32'h0);
        end
        if (rd_chk) begin
          chk("redir_req", 32'(imem_req_valid), 32'h1);
          chk("redir_addr", imem_req_addr, rd_tgt);
          rd_chk = 0;
        end
        if (inst_valid && !p_v && acc_v) begin
          chk("fetch_lat", 32'(cyc - acc_c), 32'(acc_l + 2));
          acc_v = 0;
        end
        if (inst_valid && inst_ready && !redirect_valid) begin
          idle = 0;
          if (sb.size() == 0) begin
            chk("sb_empty", 32'h0, 32'h1);
          end else begin
            e = sb.pop_front();
            chk("inst_pc", inst_pc, e.pc);
            chk("inst_data", inst_data, e.data);
            chk("inst_fault", 32'(inst_fault), 32'(e.fault));
            sb.push_back(mk(e.pc + 32'd4));
          end
        end
        if (redirect_valid) begin
          idle = 0;
          acc_v = 0;
          sb.delete();
          sb.push_back(mk(redirect_addr));
          if (redirect_addr[1:0] == 2'b00 && !pend &&
              !(imem_req_valid && imem_req_ready)) begin
            rd_chk = 1;
            rd_tgt = redirect_addr;
          end
        end
        idle++;
        if (idle > 80) begin
          chk("watchdog", 32'(idle), 32'h0);
          idle = 0;
        end
      end
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      imem_rsp_err   = 1'b0;
      if (rst && pend) begin
        if (lat == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mdata(paddr);
          imem_rsp_err   = merr(paddr);
          pend = 0;
        end else begin
          lat--;
        end
      end else if (($urandom % 8) == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_err   = 1'($urandom % 2);
      end
      if (rst && imem_req_valid && imem_req_ready) begin
        pend  = 1;
        paddr = imem_req_addr;
        lat   = int'($urandom % 4);
        acc_v = !redirect_valid;
        acc_c = cyc;
        acc_l = lat;
      end
      p_rst = rst;
      p_v   = inst_valid;
      p_rdy = inst_ready;
      p_rd  = redirect_valid;
      p_d   = inst_data;
      p_pc  = inst_pc;
      p_f   = inst_fault;
      p_rv  = imem_req_valid;
      p_rr  = imem_req_ready;
      p_ra  = imem_req_addr;
    end
  end

endmodule
